// File: rtl/qpsk_pulse_shaper_tx.sv
`default_nettype none
// ============================================================================
// Module   : qpsk_pulse_shaper_tx
// Function : QPSK mapper, x4 zero-stuffing and 33-tap RRC transmit shaping
//            per rail, evaluated in polyphase form over a 9-symbol line.
// Revision : 1.0  initial release
// ============================================================================
module qpsk_pulse_shaper_tx #(
  parameter int DATA_WIDTH     = 16,
  parameter int COEFF_WIDTH    = 16,
  parameter int N              = 33,
  parameter int SPS            = 4,
  parameter int TAPS_PER_PHASE = 9
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sample_en,
  input  logic                         sym_valid,
  input  logic                         sym_i,
  input  logic                         sym_q,
  output logic                         sym_ready,
  output logic signed [DATA_WIDTH-1:0] out_i,
  output logic signed [DATA_WIDTH-1:0] out_q,
  output logic                         out_valid,
  output logic                         underrun
);

  localparam int ACC_W = 24;
  localparam logic signed [ACC_W-1:0] C_SAT_MAX = ACC_W'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] C_SAT_MIN = -ACC_W'(2 ** (DATA_WIDTH - 1));
  localparam logic signed [1:0]       C_POS     = 2'sb01;
  localparam logic signed [1:0]       C_NEG     = 2'sb11;

  logic        [1:0]            phase_q, phase_d;
  logic signed [1:0]            line_i_q [TAPS_PER_PHASE];
  logic signed [1:0]            line_i_d [TAPS_PER_PHASE];
  logic signed [1:0]            line_q_q [TAPS_PER_PHASE];
  logic signed [1:0]            line_q_d [TAPS_PER_PHASE];
  logic signed [DATA_WIDTH-1:0] out_i_q, out_i_d, out_q_q, out_q_d;
  logic                         out_valid_q, out_valid_d;
  logic                         underrun_q, underrun_d;
  logic signed [ACC_W-1:0]      acc_i, acc_q;

  // Only the first half of the symmetric table is stored; upper taps mirror it.
  function automatic logic signed [COEFF_WIDTH-1:0] coeff(input int idx);
    int k;
    k = (idx > (N - 1) / 2) ? (N - 1 - idx) : idx;
    case (k)
      0:       coeff = COEFF_WIDTH'(49);
      1:       coeff = COEFF_WIDTH'(58);
      2:       coeff = COEFF_WIDTH'(-7);
      3:       coeff = COEFF_WIDTH'(-105);
      4:       coeff = COEFF_WIDTH'(-136);
      5:       coeff = COEFF_WIDTH'(-26);
      6:       coeff = COEFF_WIDTH'(184);
      7:       coeff = COEFF_WIDTH'(331);
      8:       coeff = COEFF_WIDTH'(232);
      9:       coeff = COEFF_WIDTH'(-156);
      10:      coeff = COEFF_WIDTH'(-629);
      11:      coeff = COEFF_WIDTH'(-798);
      12:      coeff = COEFF_WIDTH'(-307);
      13:      coeff = COEFF_WIDTH'(912);
      14:      coeff = COEFF_WIDTH'(2521);
      15:      coeff = COEFF_WIDTH'(3893);
      16:      coeff = COEFF_WIDTH'(4432);
      default: coeff = '0;
    endcase
  endfunction

  // A line entry is +1, -1 or 0, so the product reduces to +h, -h or 0.
  function automatic logic signed [ACC_W-1:0] tap(input logic signed [1:0] s, input int idx);
    logic signed [ACC_W-1:0] c;
    c = ACC_W'(coeff(idx));
    if (s == C_POS)      tap = c;
    else if (s == C_NEG) tap = -c;
    else                 tap = '0;
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [ACC_W-1:0] a);
    if (a > C_SAT_MAX)      sat = DATA_WIDTH'(C_SAT_MAX);
    else if (a < C_SAT_MIN) sat = DATA_WIDTH'(C_SAT_MIN);
    else                    sat = DATA_WIDTH'(a);
  endfunction

  always_comb begin
    phase_d     = phase_q;
    line_i_d    = line_i_q;
    line_q_d    = line_q_q;
    out_i_d     = out_i_q;
    out_q_d     = out_q_q;
    out_valid_d = 1'b0;
    underrun_d  = 1'b0;
    acc_i       = '0;
    acc_q       = '0;
    if (sample_en) begin
      phase_d     = phase_q + 2'd1;
      out_valid_d = 1'b1;
      if (phase_q == 2'd0) begin
        for (int k = TAPS_PER_PHASE - 1; k > 0; k--) begin
          line_i_d[k] = line_i_q[k-1];
          line_q_d[k] = line_q_q[k-1];
        end
        if (sym_valid) begin
          line_i_d[0] = sym_i ? C_NEG : C_POS;
          line_q_d[0] = sym_q ? C_NEG : C_POS;
        end else begin
          line_i_d[0] = 2'sb00;
          line_q_d[0] = 2'sb00;
          underrun_d  = 1'b1;
        end
      end
      // Phase p of the polyphase filter uses taps p, p+4, ... up to N-1.
      for (int k = 0; k < TAPS_PER_PHASE; k++) begin
        if (SPS * k + int'(phase_q) <= N - 1) begin
          acc_i = acc_i + tap(line_i_d[k], SPS * k + int'(phase_q));
          acc_q = acc_q + tap(line_q_d[k], SPS * k + int'(phase_q));
        end
      end
      out_i_d = sat(acc_i);
      out_q_d = sat(acc_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q     <= 2'd0;
      for (int k = 0; k < TAPS_PER_PHASE; k++) begin
        line_i_q[k] <= 2'sb00;
        line_q_q[k] <= 2'sb00;
      end
      out_i_q     <= '0;
      out_q_q     <= '0;
      out_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      line_i_q    <= line_i_d;
      line_q_q    <= line_q_d;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
      out_valid_q <= out_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  assign sym_ready = sample_en & (phase_q == 2'd0) & reset;
  assign out_i     = out_i_q;
  assign out_q     = out_q_q;
  assign out_valid = out_valid_q;
  assign underrun  = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_qpsk_pulse_shaper_tx.sv
`default_nettype none
// Directed bench for qpsk_pulse_shaper_tx: hand-derived sequences plus a
// strobe-indexed convolution reference over the zero-stuffed symbol stream.
module tb_qpsk_pulse_shaper_tx;

  logic               clk       = 1'b0;
  logic               reset     = 1'b1;
  logic               sample_en = 1'b0;
  logic               sym_valid = 1'b0;
  logic               sym_i     = 1'b0;
  logic               sym_q     = 1'b0;
  logic               sym_ready;
  logic signed [15:0] out_i, out_q;
  logic               out_valid, underrun;

  int n_vec = 0;
  int n_err = 0;

  int h_tab [33] = '{49, 58, -7, -105, -136, -26, 184, 331, 232, -156, -629, -798, -307,
                     912, 2521, 3893, 4432, 3893, 2521, 912, -307, -798, -629, -156, 232,
                     331, 184, -26, -136, -105, -7, 58, 49};
  int steady [4] = '{4108, 4109, 4138, 4109};

  int hist_i[$];
  int hist_q[$];
  int m_phase = 0;
  int exp_i   = 0;
  int exp_q   = 0;
  bit exp_ur  = 1'b0;
  bit rdy_seen;

  qpsk_pulse_shaper_tx dut (
    .clk       (clk),
    .reset     (reset),
    .sample_en (sample_en),
    .sym_valid (sym_valid),
    .sym_i     (sym_i),
    .sym_q     (sym_q),
    .sym_ready (sym_ready),
    .out_i     (out_i),
    .out_q     (out_q),
    .out_valid (out_valid),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic int conv(input int q[$]);
    int s = 0;
    for (int j = 0; j < 33; j++) begin
      if (q.size() - 1 - j >= 0) s += h_tab[j] * q[q.size() - 1 - j];
    end
    return s;
  endfunction

  task automatic model_clear();
    hist_i.delete();
    hist_q.delete();
    m_phase = 0;
    exp_i   = 0;
    exp_q   = 0;
  endtask

  // One sample_en strobe; updates the reference model and returns after the edge.
  task automatic strobe(input bit v, input bit si, input bit sq);
    @(negedge clk);
    sample_en = 1'b1;
    sym_valid = v;
    sym_i     = si;
    sym_q     = sq;
    #1 rdy_seen = sym_ready;
    exp_ur = (m_phase == 0) && !v;
    if (m_phase == 0 && v) begin
      hist_i.push_back(si ? -1 : 1);
      hist_q.push_back(sq ? -1 : 1);
    end else begin
      hist_i.push_back(0);
      hist_q.push_back(0);
    end
    m_phase = (m_phase + 1) % 4;
    exp_i   = conv(hist_i);
    exp_q   = conv(hist_q);
    @(posedge clk);
    #1 sample_en = 1'b0;
  endtask

  task automatic idle_clk();
    @(negedge clk);
    sample_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic align(input int target);
    while (m_phase != target) strobe(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 sample_en = 1'b1;
    #1;
    n_vec++; if (sym_ready !== 1'b0) begin n_err++; $display("FAIL reset sym_ready: got %b, expected 0", sym_ready); end
    n_vec++; if (out_i !== 16'sd0) begin n_err++; $display("FAIL reset out_i: got %0d, expected 0", out_i); end
    n_vec++; if (out_q !== 16'sd0) begin n_err++; $display("FAIL reset out_q: got %0d, expected 0", out_q); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b, expected 0", out_valid); end
    n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL reset underrun: got %b, expected 0", underrun); end
    sample_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_impulse(input string tag);
    int e;
    for (int n = 0; n < 40; n++) begin
      strobe(n == 0, 1'b0, 1'b1);
      e = (n < 33) ? h_tab[n] : 0;
      if (n == 0) begin
        n_vec++; if (rdy_seen !== 1'b1) begin n_err++; $display("FAIL %s sym_ready at accept: got %b, expected 1", tag, rdy_seen); end
      end
      n_vec++; if (out_i !== e) begin n_err++; $display("FAIL %s out_i[%0d]: got %0d, expected %0d", tag, n, out_i, e); end
      n_vec++; if (out_q !== -e) begin n_err++; $display("FAIL %s out_q[%0d]: got %0d, expected %0d", tag, n, out_q, -e); end
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL %s out_valid[%0d]: got %b, expected 1", tag, n, out_valid); end
      n_vec++;
      if (underrun !== ((n % 4 == 0) && (n > 0))) begin
        n_err++; $display("FAIL %s underrun[%0d]: got %b, expected %b", tag, n, underrun, (n % 4 == 0) && (n > 0));
      end
    end
  endtask

  task automatic test_steady();
    align(0);
    for (int n = 0; n < 48; n++) begin
      strobe(1'b1, 1'b0, 1'b0);
      n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL steady underrun[%0d]: got %b, expected 0", n, underrun); end
      if (n >= 32) begin
        n_vec++; if (out_i !== steady[n % 4]) begin n_err++; $display("FAIL steady out_i[%0d]: got %0d, expected %0d", n, out_i, steady[n % 4]); end
        n_vec++; if (out_q !== steady[n % 4]) begin n_err++; $display("FAIL steady out_q[%0d]: got %0d, expected %0d", n, out_q, steady[n % 4]); end
      end else begin
        n_vec++; if (out_i !== exp_i) begin n_err++; $display("FAIL steady fill out_i[%0d]: got %0d, expected %0d", n, out_i, exp_i); end
      end
    end
  endtask

  task automatic test_handshake();
    align(2);
    for (int n = 0; n < 2; n++) begin
      strobe(1'b1, 1'b1, 1'b0);
      n_vec++; if (rdy_seen !== 1'b0) begin n_err++; $display("FAIL handshake sym_ready at phase %0d: got %b, expected 0", n + 2, rdy_seen); end
      n_vec++; if (out_i !== exp_i) begin n_err++; $display("FAIL handshake out_i pre: got %0d, expected %0d", out_i, exp_i); end
    end
    idle_clk();
    n_vec++; if (sym_ready !== 1'b0) begin n_err++; $display("FAIL handshake sym_ready without strobe: got %b, expected 0", sym_ready); end
    for (int n = 0; n < 24; n++) begin
      strobe(n < 4, 1'b1, 1'b0);
      if (n % 4 == 0) begin
        n_vec++; if (rdy_seen !== 1'b1) begin n_err++; $display("FAIL handshake sym_ready phase0[%0d]: got %b, expected 1", n, rdy_seen); end
      end else begin
        n_vec++; if (rdy_seen !== 1'b0) begin n_err++; $display("FAIL handshake sym_ready[%0d]: got %b, expected 0", n, rdy_seen); end
      end
      n_vec++; if (underrun !== exp_ur) begin n_err++; $display("FAIL handshake underrun[%0d]: got %b, expected %b", n, underrun, exp_ur); end
      n_vec++; if (out_i !== exp_i) begin n_err++; $display("FAIL handshake out_i[%0d]: got %0d, expected %0d", n, out_i, exp_i); end
      n_vec++; if (out_q !== exp_q) begin n_err++; $display("FAIL handshake out_q[%0d]: got %0d, expected %0d", n, out_q, exp_q); end
    end
  endtask

  task automatic test_gating();
    logic [15:0] pat_i = 16'b1011_0010_1110_0101;
    logic [15:0] pat_q = 16'b0110_1100_0101_1011;
    align(0);
    for (int n = 0; n < 64; n++) begin
      strobe(1'b1, pat_i[n / 4], pat_q[n / 4]);
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL gating out_valid[%0d]: got %b, expected 1", n, out_valid); end
      n_vec++; if (out_i !== exp_i) begin n_err++; $display("FAIL gating out_i[%0d]: got %0d, expected %0d", n, out_i, exp_i); end
      n_vec++; if (out_q !== exp_q) begin n_err++; $display("FAIL gating out_q[%0d]: got %0d, expected %0d", n, out_q, exp_q); end
      for (int g = 0; g < 2; g++) begin
        idle_clk();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL gating idle out_valid[%0d]: got %b, expected 0", n, out_valid); end
        n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL gating idle underrun[%0d]: got %b, expected 0", n, underrun); end
        n_vec++; if (out_i !== exp_i) begin n_err++; $display("FAIL gating hold out_i[%0d]: got %0d, expected %0d", n, out_i, exp_i); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    align(0);
    for (int n = 0; n < 12; n++) strobe(1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    n_vec++; if (out_i !== 16'sd0) begin n_err++; $display("FAIL midreset out_i: got %0d, expected 0", out_i); end
    n_vec++; if (out_q !== 16'sd0) begin n_err++; $display("FAIL midreset out_q: got %0d, expected 0", out_q); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midreset out_valid: got %b, expected 0", out_valid); end
    sample_en = 1'b1;
    #1;
    n_vec++; if (sym_ready !== 1'b0) begin n_err++; $display("FAIL midreset sym_ready: got %b, expected 0", sym_ready); end
    sample_en = 1'b0;
    idle_clk();
    idle_clk();
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    test_impulse("post_reset_impulse");
  endtask

  task automatic test_sign_mix();
    int past[$];
    bit b;
    align(0);
    for (int n = 0; n < 36; n++) strobe(1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 80; n++) begin
      b = ((n / 4) % 2) == 1;
      strobe(n % 4 == 0, b, b);
      past.push_back(exp_i);
      n_vec++; if (out_i !== exp_i) begin n_err++; $display("FAIL signmix out_i[%0d]: got %0d, expected %0d", n, out_i, exp_i); end
      n_vec++; if (out_q !== exp_q) begin n_err++; $display("FAIL signmix out_q[%0d]: got %0d, expected %0d", n, out_q, exp_q); end
      if (n >= 36) begin
        n_vec++; if (out_i !== -past[n - 4]) begin n_err++; $display("FAIL signmix alternation[%0d]: got %0d, expected %0d", n, out_i, -past[n - 4]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse("impulse");
    test_steady();
    test_handshake();
    test_gating();
    test_reset_midstream();
    test_sign_mix();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
